// File: rtl/correlator_adder_cascade.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : correlator_adder_cascade
// Description : Six-stage registered systolic adder that totals the twelve
//               operands of one correlation word per clock (unsigned, modulo
//               2^DSPBITS). An optional peak-hold block tracks the largest
//               SUM in each WINDOW-sample window and reports its position.
//               The peak-hold block is built only when the macro
//               CORRELATOR_PEAK_HOLD_EN is defined; otherwise PEAK,
//               PEAK_INDEX and PEAK_VALID are constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module correlator_adder_cascade #(
    parameter int DSPBITS = 12,
    parameter int WINDOW  = 64,
    parameter int IDXBITS = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DSPBITS-1:0] STAGE1A,
    input  logic [DSPBITS-1:0] STAGE1B,
    input  logic [DSPBITS-1:0] STAGE2A,
    input  logic [DSPBITS-1:0] STAGE2B,
    input  logic [DSPBITS-1:0] STAGE3A,
    input  logic [DSPBITS-1:0] STAGE3B,
    input  logic [DSPBITS-1:0] STAGE4A,
    input  logic [DSPBITS-1:0] STAGE4B,
    input  logic [DSPBITS-1:0] STAGE5A,
    input  logic [DSPBITS-1:0] STAGE5B,
    input  logic [DSPBITS-1:0] STAGE6A,
    input  logic [DSPBITS-1:0] STAGE6B,
    input  logic               IN_VALID,
    output logic [DSPBITS-1:0] SUM,
    output logic               SUM_VALID,
    output logic [DSPBITS-1:0] PEAK,
    output logic [IDXBITS-1:0] PEAK_INDEX,
    output logic               PEAK_VALID
);

    // Counter value of the last sample in a window.
    localparam logic [IDXBITS-1:0] c_last_idx = IDXBITS'(WINDOW - 1);

    // ------------------------------------------------------------------------
    // Operand skew registers. Stage k consumes its operands k-1 clocks after
    // the word entered stage 1. STAGE5/6 already arrive one clock late, so
    // they need one register fewer than their stage position implies.
    // ------------------------------------------------------------------------
    logic [DSPBITS-1:0] r_s2a;
    logic [DSPBITS-1:0] r_s2b;
    logic [DSPBITS-1:0] r_s3a_d [0:1];
    logic [DSPBITS-1:0] r_s3b_d [0:1];
    logic [DSPBITS-1:0] r_s4a_d [0:2];
    logic [DSPBITS-1:0] r_s4b_d [0:2];
    logic [DSPBITS-1:0] r_s5a_d [0:2];
    logic [DSPBITS-1:0] r_s5b_d [0:2];
    logic [DSPBITS-1:0] r_s6a_d [0:3];
    logic [DSPBITS-1:0] r_s6b_d [0:3];

    // Partial sums of the cascade; r_p6 is the full twelve-operand total.
    logic [DSPBITS-1:0] r_p1;
    logic [DSPBITS-1:0] r_p2;
    logic [DSPBITS-1:0] r_p3;
    logic [DSPBITS-1:0] r_p4;
    logic [DSPBITS-1:0] r_p5;
    logic [DSPBITS-1:0] r_p6;

    // IN_VALID travels alongside the word; bit 5 lines up with r_p6.
    logic [5:0]         r_vld_sr;

    // Shift operands through their skew chains so each stage sees one word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2a <= '0;
            r_s2b <= '0;
            for (int i = 0; i < 2; i++) begin
                r_s3a_d[i] <= '0;
                r_s3b_d[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                r_s4a_d[i] <= '0;
                r_s4b_d[i] <= '0;
                r_s5a_d[i] <= '0;
                r_s5b_d[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                r_s6a_d[i] <= '0;
                r_s6b_d[i] <= '0;
            end
        end else begin
            r_s2a      <= STAGE2A;
            r_s2b      <= STAGE2B;
            r_s3a_d[0] <= STAGE3A;
            r_s3b_d[0] <= STAGE3B;
            r_s3a_d[1] <= r_s3a_d[0];
            r_s3b_d[1] <= r_s3b_d[0];
            r_s4a_d[0] <= STAGE4A;
            r_s4b_d[0] <= STAGE4B;
            r_s5a_d[0] <= STAGE5A;
            r_s5b_d[0] <= STAGE5B;
            for (int i = 1; i < 3; i++) begin
                r_s4a_d[i] <= r_s4a_d[i-1];
                r_s4b_d[i] <= r_s4b_d[i-1];
                r_s5a_d[i] <= r_s5a_d[i-1];
                r_s5b_d[i] <= r_s5b_d[i-1];
            end
            r_s6a_d[0] <= STAGE6A;
            r_s6b_d[0] <= STAGE6B;
            for (int i = 1; i < 4; i++) begin
                r_s6a_d[i] <= r_s6a_d[i-1];
                r_s6b_d[i] <= r_s6b_d[i-1];
            end
        end
    end

    // Systolic adder cascade; sums wrap modulo 2^DSPBITS by truncation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1 <= '0;
            r_p2 <= '0;
            r_p3 <= '0;
            r_p4 <= '0;
            r_p5 <= '0;
            r_p6 <= '0;
        end else begin
            r_p1 <= STAGE1A + STAGE1B;
            r_p2 <= r_p1 + r_s2a + r_s2b;
            r_p3 <= r_p2 + r_s3a_d[1] + r_s3b_d[1];
            r_p4 <= r_p3 + r_s4a_d[2] + r_s4b_d[2];
            r_p5 <= r_p4 + r_s5a_d[2] + r_s5b_d[2];
            r_p6 <= r_p5 + r_s6a_d[3] + r_s6b_d[3];
        end
    end

    // Valid delay line matching the six-clock adder latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_sr <= '0;
        end else begin
            r_vld_sr <= {r_vld_sr[4:0], IN_VALID};
        end
    end

    assign SUM       = r_p6;
    assign SUM_VALID = r_vld_sr[5];

`ifdef CORRELATOR_PEAK_HOLD_EN
    // ------------------------------------------------------------------------
    // Peak hold: per-window running maximum with first-occurrence tie-break.
    // ------------------------------------------------------------------------
    logic [IDXBITS-1:0] r_cnt;
    logic [DSPBITS-1:0] r_max;
    logic [IDXBITS-1:0] r_max_idx;
    logic [DSPBITS-1:0] r_peak;
    logic [IDXBITS-1:0] r_peak_idx;
    logic               r_peak_vld;

    logic               w_take;
    logic [DSPBITS-1:0] w_max_nxt;
    logic [IDXBITS-1:0] w_idx_nxt;

    // The first sample of a window always seeds the maximum; later samples
    // replace it only when strictly larger, so the earliest tie is kept.
    always_comb begin
        w_take    = (r_cnt == '0) || (r_p6 > r_max);
        w_max_nxt = r_max;
        w_idx_nxt = r_max_idx;
        if (w_take) begin
            w_max_nxt = r_p6;
            w_idx_nxt = r_cnt;
        end
    end

    // Advance the window on valid sums; publish the result on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_max      <= '0;
            r_max_idx  <= '0;
            r_peak     <= '0;
            r_peak_idx <= '0;
            r_peak_vld <= 1'b0;
        end else begin
            r_peak_vld <= 1'b0;
            if (r_vld_sr[5]) begin
                r_max     <= w_max_nxt;
                r_max_idx <= w_idx_nxt;
                if (r_cnt == c_last_idx) begin
                    r_cnt      <= '0;
                    r_peak     <= w_max_nxt;
                    r_peak_idx <= w_idx_nxt;
                    r_peak_vld <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign PEAK       = r_peak;
    assign PEAK_INDEX = r_peak_idx;
    assign PEAK_VALID = r_peak_vld;
`else
    // Peak hold not built: outputs are tied off.
    logic w_unused_window;
    assign w_unused_window = ^c_last_idx;

    assign PEAK       = '0;
    assign PEAK_INDEX = '0;
    assign PEAK_VALID = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_correlator_adder_cascade.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_correlator_adder_cascade
// Description : Directed self-checking bench for correlator_adder_cascade
//               (WINDOW=4). Peak expectations follow CORRELATOR_PEAK_HOLD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_correlator_adder_cascade;

    localparam int DW = 12;
    localparam int IW = 6;
`ifdef CORRELATOR_PEAK_HOLD_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s1a, s1b, s2a, s2b, s3a, s3b, s4a, s4b;
    logic [DW-1:0] s5a, s5b, s6a, s6b;
    logic          in_valid;
    logic [DW-1:0] sum;
    logic          sum_valid;
    logic [DW-1:0] peak;
    logic [IW-1:0] peak_index;
    logic          peak_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;
    logic [DW-1:0] pk_vals [0:3];

    correlator_adder_cascade #(
        .DSPBITS (DW),
        .WINDOW  (4),
        .IDXBITS (IW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .STAGE1A    (s1a),
        .STAGE1B    (s1b),
        .STAGE2A    (s2a),
        .STAGE2B    (s2b),
        .STAGE3A    (s3a),
        .STAGE3B    (s3b),
        .STAGE4A    (s4a),
        .STAGE4B    (s4b),
        .STAGE5A    (s5a),
        .STAGE5B    (s5b),
        .STAGE6A    (s6a),
        .STAGE6B    (s6b),
        .IN_VALID   (in_valid),
        .SUM        (sum),
        .SUM_VALID  (sum_valid),
        .PEAK       (peak),
        .PEAK_INDEX (peak_index),
        .PEAK_VALID (peak_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: STAGE1..4 = x14 (STAGE1A gets +extra), STAGE5/6 = x56.
    task automatic step(input logic [DW-1:0] x14, input logic [DW-1:0] x56,
                        input logic vld, input logic [DW-1:0] extra);
        s1a = x14 + extra; s1b = x14; s2a = x14; s2b = x14;
        s3a = x14; s3b = x14; s4a = x14; s4b = x14;
        s5a = x56; s5b = x56; s6a = x56; s6b = x56;
        in_valid = vld;
        @(posedge clk);
        #1;
`ifndef CORRELATOR_PEAK_HOLD_EN
        chk("peak_off", 32'(peak), 32'h0);
        chk("peak_index_off", 32'(peak_index), 32'h0);
        chk("peak_valid_off", 32'(peak_valid), 32'h0);
`endif
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sum"}, 32'(sum), 32'h0);
        chk({tag, "_sum_valid"}, 32'(sum_valid), 32'h0);
        chk({tag, "_peak"}, 32'(peak), 32'h0);
        chk({tag, "_peak_index"}, 32'(peak_index), 32'h0);
        chk({tag, "_peak_valid"}, 32'(peak_valid), 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk_reset_state("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        s1a = '0; s1b = '0; s2a = '0; s2b = '0; s3a = '0; s3b = '0;
        s4a = '0; s4b = '0; s5a = '0; s5b = '0; s6a = '0; s6b = '0;
        in_valid = 1'b0;
        pk_vals[0] = 12'd5; pk_vals[1] = 12'd9; pk_vals[2] = 12'd9; pk_vals[3] = 12'd3;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("por");
        rst_n = 1'b1;

        // Single word of all ones: SUM=12 six clocks later, one-clock valid
        step(12'd1, 12'd0, 1'b1, 12'd0);
        chk("single_valid_1", 32'(sum_valid), 32'h0);
        for (int i = 2; i <= 7; i++) begin
            step(12'd0, (i == 2) ? 12'd1 : 12'd0, 1'b0, 12'd0);
            if (i == 6) begin
                chk("single_sum", 32'(sum), 32'd12);
                chk("single_valid_6", 32'(sum_valid), 32'h1);
            end else begin
                chk("single_valid_n", 32'(sum_valid), 32'h0);
            end
        end

        // Back-to-back words n=1..8
        for (int i = 1; i <= 13; i++) begin
            step((i <= 8) ? 12'(i) : 12'd0,
                 (i >= 2 && i <= 9) ? 12'(i - 1) : 12'd0,
                 (i <= 8), 12'd0);
            if (i >= 6) begin
                chk("b2b_sum", 32'(sum), 32'(12 * (i - 5)));
                chk("b2b_valid", 32'(sum_valid), 32'h1);
            end else begin
                chk("b2b_valid_pre", 32'(sum_valid), 32'h0);
            end
        end
        step(12'd0, 12'd0, 1'b0, 12'd0);
        chk("b2b_valid_post", 32'(sum_valid), 32'h0);

        // Overflow: 12 * 0x200 wraps to 0x800
        step(12'h200, 12'd0, 1'b1, 12'd0);
        step(12'd0, 12'h200, 1'b0, 12'd0);
        for (int i = 3; i <= 6; i++) step(12'd0, 12'd0, 1'b0, 12'd0);
        chk("ovf_sum", 32'(sum), 32'h800);
        chk("ovf_valid", 32'(sum_valid), 32'h1);

        // Peak window: SUMs 5,9,9,3 -> PEAK=9 at index 1
        do_reset();
        for (int i = 1; i <= 11; i++) begin
            step(12'd0, 12'd0, (i <= 4), (i <= 4) ? pk_vals[i-1] : 12'd0);
            if (i >= 6 && i <= 9) chk("pk_sum", 32'(sum), 32'(pk_vals[i-6]));
            if (i == 9) chk("pk_valid_early", 32'(peak_valid), 32'h0);
            if (i == 10) begin
                chk("pk_valid", 32'(peak_valid), 32'(PEAK_EN));
                chk("pk_peak", 32'(peak), PEAK_EN ? 32'd9 : 32'd0);
                chk("pk_index", 32'(peak_index), PEAK_EN ? 32'd1 : 32'd0);
            end
            if (i == 11) begin
                chk("pk_valid_once", 32'(peak_valid), 32'h0);
                chk("pk_peak_hold", 32'(peak), PEAK_EN ? 32'd9 : 32'd0);
                chk("pk_index_hold", 32'(peak_index), PEAK_EN ? 32'd1 : 32'd0);
            end
        end

        // Reset mid-window after two samples, then four samples of 7
        do_reset();
        for (int i = 1; i <= 8; i++) step(12'd0, 12'd0, (i <= 2), (i <= 2) ? 12'd4 : 12'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            step(12'd0, 12'd0, (i <= 4), (i <= 4) ? 12'd7 : 12'd0);
            if (i <= 6) chk("midrst_sum_valid", 32'(sum_valid), (i == 6) ? 32'h1 : 32'h0);
            if (peak_valid === 1'b1) pulses++;
            if (i == 10) begin
                chk("midrst_valid", 32'(peak_valid), 32'(PEAK_EN));
                chk("midrst_peak", 32'(peak), PEAK_EN ? 32'd7 : 32'd0);
                chk("midrst_index", 32'(peak_index), 32'd0);
            end
        end
        chk("midrst_pulses", 32'(pulses), PEAK_EN ? 32'd1 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/correlator_adder_cascade.md
CORRELATOR_ADDER_CASCADE -- requirements
Module: correlator_adder_cascade

Interface
REQ-001 SHALL have parameter DSPBITS, default 12: width of every stage operand and of SUM.
REQ-002 SHALL have parameter WINDOW, default 64: peak-hold window length in valid samples, legal range 2..2^IDXBITS.
REQ-003 SHALL have parameter IDXBITS, default 6: width of PEAK_INDEX.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port STAGE1A..STAGE4A and STAGE1B..STAGE4B, input, DSPBITS each: unregistered operands of correlation word t.
REQ-007 SHALL have port STAGE5A, STAGE5B, STAGE6A and STAGE6B, input, DSPBITS each: pre-added operands of word t, presented one clock after that word's STAGE1..4.
REQ-008 SHALL have port IN_VALID, input, 1: qualifies STAGE1..4 of word t.
REQ-009 SHALL have port SUM, output, DSPBITS: the total of all 12 operands of one word.
REQ-010 SHALL have port SUM_VALID, output, 1: qualifies SUM.
REQ-011 SHALL have port PEAK, output, DSPBITS: the largest SUM seen in the last completed window.
REQ-012 SHALL have port PEAK_INDEX, output, IDXBITS: the position of PEAK within its window.
REQ-013 SHALL have port PEAK_VALID, output, 1: one-clock pulse when a window completes.

Function
REQ-014 SHALL implement a 6-stage registered systolic adder, stage k of the form P_k <= P_(k-1) + A_k + B_k, with P_0 = 0.
REQ-015 SHALL skew inputs so that every stage adds operands of the same word:
- STAGE1..4 inputs delayed k-1 clocks.
- STAGE5 inputs delayed 3 clocks.
- STAGE6 inputs delayed 4 clocks.
REQ-016 SHALL present SUM for word t exactly 6 clocks after STAGE1..4 of word t are presented.
REQ-017 SHALL take one new word every clock, with no stalls and no backpressure.
REQ-018 SHALL delay IN_VALID through a matching 6-deep shift register to form SUM_VALID.
REQ-019 SHALL update SUM every clock regardless of valid; SUM is meaningful only when SUM_VALID=1.
REQ-020 SHALL compute all sums unsigned, truncated modulo 2^DSPBITS, with no saturation.
REQ-021 SHALL, in the peak-hold path, advance a sample counter only on SUM_VALID=1, counting 0..WINDOW-1 and then wrapping to 0.
REQ-022 SHALL load the running maximum with SUM at counter=0; otherwise it SHALL replace the maximum only when SUM > max, so the first occurrence wins ties.
REQ-023 SHALL, on the valid sample where counter=WINDOW-1:
- register the final max into PEAK and its counter value into PEAK_INDEX;
- pulse PEAK_VALID high for exactly one clock;
- include that last sample in the comparison.
REQ-024 SHALL hold PEAK and PEAK_INDEX between windows.
REQ-025 SHALL let SUM_VALID=0 cycles pause the window without resetting it.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear:
- all pipeline and skew registers;
- SUM, SUM_VALID, PEAK, PEAK_INDEX and PEAK_VALID to 0;
- the window counter to 0.
REQ-027 SHALL, on rst_n assertion mid-window, discard the partial window, and SHALL emit no PEAK_VALID for it.
REQ-028 SHALL keep SUM_VALID low for the first 6 clocks after release, until valid words have propagated.

Configuration
REQ-029 SHALL compile the peak-hold logic (REQ-021..025) only when macro CORRELATOR_PEAK_HOLD_EN is defined.
REQ-030 SHALL, when CORRELATOR_PEAK_HOLD_EN is undefined, tie PEAK, PEAK_INDEX and PEAK_VALID to constant 0 and instantiate no counter or comparator; SUM and SUM_VALID behaviour SHALL be unchanged.

Verification
REQ-031 SHALL cover single word: all 12 operands = 1 (STAGE5/6 one clock later), IN_VALID pulse -> SUM=12 with SUM_VALID high for exactly one clock, 6 clocks later.
REQ-032 SHALL cover back-to-back: words with operand value n for n=1..8 on consecutive clocks -> SUM = 12n on 8 consecutive clocks, with no cross-word mixing.
REQ-033 SHALL cover overflow: all operands = 12'h200 -> SUM = 12'h800 (12*0x200 mod 4096).
REQ-034 SHALL cover peak with CORRELATOR_PEAK_HOLD_EN defined and WINDOW=4: SUMs 5,9,9,3 -> PEAK=9, PEAK_INDEX=1, one PEAK_VALID pulse.
REQ-035 SHALL cover reset mid-window: rst_n low after 2 of 4 samples, then 4 new samples of SUM=7 -> exactly one PEAK_VALID with PEAK=7, PEAK_INDEX=0.
REQ-036 SHALL cover the macro undefined: any stimulus -> PEAK, PEAK_INDEX and PEAK_VALID constantly 0, with SUM results identical to REQ-031.
